// File: rtl/alu_frame_if.sv
// Byte-stream, ALU and result signals of the ALU frame controller.
// The master side is the byte source, ALU and result consumer.
interface alu_frame_if;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] ina;
    logic [15:0] inb;
    logic [1:0]  sel;
    logic [15:0] alu_out;
    logic        alu_ov;
    logic [15:0] res;
    logic        res_ov;
    logic        res_valid;
    logic        res_ack;
    logic        busy;
    logic        err;

    modport master (
        output din, din_valid, alu_out, alu_ov, res_ack,
        input  din_ready, ina, inb, sel, res, res_ov, res_valid, busy, err
    );

    modport slave (
        input  din, din_valid, alu_out, alu_ov, res_ack,
        output din_ready, ina, inb, sel, res, res_ov, res_valid, busy, err
    );
endinterface

// File: rtl/alu_frame_ctrl.sv
// Byte-serial operand framer and result capture for the 16-bit ALU.
// Frame: A_hi A_lo B_hi B_lo OP; result held until acknowledged.
module alu_frame_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 1000
) (
    input logic        clk,
    input logic        rst,
    alu_frame_if.slave bus
);
    typedef enum logic [2:0] {
        A_HI, A_LO, B_HI, B_LO, OP, EXEC, HOLD
    } state_t;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [TW-1:0] idle_cnt;
    logic [3:0]    lat_cnt;
    logic          loading;
    logic          xfer;
    logic          timeout;

    assign loading = (state == A_HI) || (state == A_LO) ||
                     (state == B_HI) || (state == B_LO) ||
                     (state == OP);
    assign bus.din_ready = loading && !rst;
    assign xfer = bus.din_valid && bus.din_ready;
    // Abort on the idle edge that would bring the counter to TIMEOUT-1.
    assign timeout = loading && (state != A_HI) && !xfer &&
                     (idle_cnt == TW'(TIMEOUT - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= A_HI;
            idle_cnt      <= '0;
            lat_cnt       <= '0;
            bus.ina       <= '0;
            bus.inb       <= '0;
            bus.sel       <= '0;
            bus.res       <= '0;
            bus.res_ov    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            if (xfer || timeout || !loading || state == A_HI)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (timeout) begin
                state    <= A_HI;
                bus.busy <= 1'b0;
                bus.err  <= 1'b1;
            end else begin
                unique case (state)
                    A_HI: if (xfer) begin
                        bus.ina[15:8] <= bus.din;
                        bus.busy      <= 1'b1;
                        state         <= A_LO;
                    end
                    A_LO: if (xfer) begin
                        bus.ina[7:0] <= bus.din;
                        state        <= B_HI;
                    end
                    B_HI: if (xfer) begin
                        bus.inb[15:8] <= bus.din;
                        state         <= B_LO;
                    end
                    B_LO: if (xfer) begin
                        bus.inb[7:0] <= bus.din;
                        state        <= OP;
                    end
                    OP: if (xfer) begin
                        if (bus.din[7:2] == 6'd0) begin
                            bus.sel <= bus.din[1:0];
                            lat_cnt <= '0;
                            state   <= EXEC;
                        end else begin
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= A_HI;
                        end
                    end
                    EXEC: begin
                        if (lat_cnt == 4'(ALU_LAT - 1)) begin
                            bus.res       <= bus.alu_out;
                            bus.res_ov    <= bus.alu_ov;
                            bus.res_valid <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    HOLD: if (bus.res_ack) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= A_HI;
                    end
                    default: begin
                        bus.busy <= 1'b0;
                        state    <= A_HI;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Scoreboard bench for alu_frame_ctrl with a behavioural ALU.
// Expected results are queued as OP bytes are driven.
module tb_alu_frame_ctrl;
    localparam int LAT = 1;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_frame_if bus ();

    alu_frame_ctrl #(
        .ALU_LAT(LAT),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    logic [16:0] sb[$];
    logic [16:0] e_res;
    logic [15:0] held;
    logic        prev_v = 1'b0;

    function automatic logic [16:0] alu_model(
        input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [16:0] s;
        logic [31:0] p;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                return s;
            end
            2'd1: return {(a < b), 16'(a - b)};
            2'd2: begin
                p = a * b;
                return {|p[31:16], p[15:0]};
            end
            default: return (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, 16'(a / b)};
        endcase
    endfunction

    always_comb {bus.alu_ov, bus.alu_out} = alu_model(bus.ina, bus.inb, bus.sel);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (bus.err) err_cnt++;
            if (bus.res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexp_res", sb.size(), 1);
                end else begin
                    e_res = sb.pop_front();
                    chk("res", bus.res, e_res[15:0]);
                    chk("res_ov", bus.res_ov, e_res[16]);
                    held = e_res[15:0];
                end
            end else if (bus.res_valid) begin
                chk("res_stable", bus.res, held);
            end
            prev_v = bus.res_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.din = b;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_tmo", n, 0);
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [7:0] op, output int span);
        int c0;
        send_byte(a[15:8]);
        c0 = cyc;
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
        if (op[7:2] == 6'd0) sb.push_back(alu_model(a, b, op[1:0]));
        send_byte(op);
        span = cyc - c0;
    endtask

    task automatic wait_res();
        int n = 0;
        while (!bus.res_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("res_tmo", n, 0);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.res_ack = 1'b1;
        @(posedge clk);
        #1 bus.res_ack = 1'b0;
        chk("ack_rv", bus.res_valid, 0);
        chk("ack_rdy", bus.din_ready, 1);
        chk("ack_busy", bus.busy, 0);
    endtask

    initial begin
        int span;
        int e0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.res_ack = 1'b0;
        #12;
        chk("rst_ina", bus.ina, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_rdy", bus.din_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.res_valid, 0);
        chk("rst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("idle_rdy", bus.din_ready, 1);

        // add: back-to-back bytes, one-cycle capture latency
        send_frame(16'h1234, 16'h0101, 8'h00, span);
        chk("xfer_span", span, 4);
        chk("t1_ina", bus.ina, 16'h1234);
        chk("t1_inb", bus.inb, 16'h0101);
        chk("t1_sel", bus.sel, 0);
        chk("t1_rv_early", bus.res_valid, 0);
        chk("t1_busy", bus.busy, 1);
        chk("t1_rdy_exec", bus.din_ready, 0);
        repeat (LAT) @(posedge clk);
        #1 chk("t1_rv", bus.res_valid, 1);
        chk("t1_res", bus.res, 16'h1335);
        ack();

        // div held without ack
        send_frame(16'h0064, 16'h0007, 8'h03, span);
        wait_res();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t2_rv_hold", bus.res_valid, 1);
            chk("t2_rdy_hold", bus.din_ready, 0);
        end
        chk("t2_res", bus.res, 16'h000E);
        ack();

        // mul
        send_frame(16'h7FFF, 16'h0002, 8'h02, span);
        wait_res();
        chk("t3_ina", bus.ina, 16'h7FFF);
        chk("t3_inb", bus.inb, 16'h0002);
        chk("t3_sel", bus.sel, 2);
        ack();

        // illegal op
        e0 = err_cnt;
        send_frame(16'h0001, 16'h0001, 8'h07, span);
        chk("t4_err", bus.err, 1);
        chk("t4_sel", bus.sel, 2);
        chk("t4_busy", bus.busy, 0);
        chk("t4_rdy", bus.din_ready, 1);
        @(posedge clk);
        #1 chk("t4_err_off", bus.err, 0);
        chk("t4_rv", bus.res_valid, 0);
        chk("t4_err_cnt", err_cnt - e0, 1);

        // add with carry
        send_frame(16'hFFFF, 16'h0001, 8'h00, span);
        wait_res();
        ack();

        // idle timeout inside a frame
        send_byte(8'h12);
        send_byte(8'h34);
        e0 = err_cnt;
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1 chk($sformatf("to_err_%0d", j), bus.err, (j == 7));
        end
        chk("to_busy", bus.busy, 0);
        chk("to_err_cnt", err_cnt - e0, 1);
        send_byte(8'hAB);
        chk("to_reload", bus.ina, 16'hAB34);
        send_byte(8'hCD);
        send_byte(8'h00);
        send_byte(8'h01);
        sb.push_back(alu_model(16'hABCD, 16'h0001, 2'd0));
        send_byte(8'h00);
        wait_res();
        ack();

        // byte on the last allowed idle cycle wins
        send_byte(8'h00);
        send_byte(8'h05);
        e0 = err_cnt;
        repeat (6) @(posedge clk);
        send_byte(8'h00);
        chk("late_no_err", err_cnt - e0, 0);
        chk("late_busy", bus.busy, 1);
        send_byte(8'h03);
        sb.push_back(alu_model(16'h0005, 16'h0003, 2'd1));
        send_byte(8'h01);
        wait_res();
        chk("late_res", bus.res, 16'h0002);
        ack();

        // async reset mid-frame
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("r1_ina", bus.ina, 0);
        chk("r1_inb", bus.inb, 0);
        chk("r1_busy", bus.busy, 0);
        chk("r1_rdy", bus.din_ready, 0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        // async reset in HOLD
        send_frame(16'h0003, 16'h0004, 8'h02, span);
        wait_res();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("r2_rv", bus.res_valid, 0);
        chk("r2_res", bus.res, 0);
        chk("r2_sel", bus.sel, 0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;

        send_frame(16'h0010, 16'h0004, 8'h01, span);
        wait_res();
        chk("r3_res", bus.res, 16'h000C);
        ack();

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
